// File: rtl/uart_rx_block_if.sv
// uart_rx_block_if: serial line, acknowledge level and holding-register outputs of the UART receiver.
interface uart_rx_block_if;

    logic       rx;
    logic       rd_ack;
    logic [7:0] data_out;
    logic       data_rdy;
    logic       overrun;
    logic       frame_err;
    logic       data_valid;
    logic       rx_busy;

    // Master drives the line and acknowledges. The receiver (slave) presents the byte and flags.
    modport master (
        output rx,
        output rd_ack,
        input  data_out,
        input  data_rdy,
        input  overrun,
        input  frame_err,
        input  data_valid,
        input  rx_busy
    );

    modport slave (
        input  rx,
        input  rd_ack,
        output data_out,
        output data_rdy,
        output overrun,
        output frame_err,
        output data_valid,
        output rx_busy
    );

endinterface

// File: rtl/uart_rx_block.sv
// uart_rx_block: 8N1 UART receiver with a sticky-flag holding register that the HPS acknowledges.
module uart_rx_block #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_block_if.slave  bus
);

    localparam int unsigned CPB   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

    // Reject bit periods too short for a centred start-bit check.
    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx_block: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // Synchronizers and acknowledge edge detect
    logic r_rx_s1;
    logic r_rx_s;
    logic r_ack_s1;
    logic r_ack_s2;
    logic r_ack_d;
    logic w_ack_rise;

    // FSM and datapath
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_busy;

    // FSM outputs
    logic               w_frame_good;
    logic               w_frame_bad;
    logic               w_busy_nxt;

    // Holding register
    logic [7:0]         r_data_out;
    logic               r_data_rdy;
    logic               r_overrun;
    logic               r_frame_err;
    logic               r_data_valid;

    // Two-flop synchronizers for rx (idle high) and rd_ack, plus the ack edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1  <= 1'b1;
            r_rx_s   <= 1'b1;
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
            r_ack_d  <= 1'b0;
        end else begin
            r_rx_s1  <= bus.rx;
            r_rx_s   <= r_rx_s1;
            r_ack_s1 <= bus.rd_ack;
            r_ack_s2 <= r_ack_s1;
            r_ack_d  <= r_ack_s2;
        end
    end

    assign w_ack_rise = r_ack_s2 & ~r_ack_d;

    // State register with the bit counter, data index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next state: half-bit start check, then full-bit sampling of data and stop bits.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == CNT_W'(HALF - 1)) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_W'(CPB - 1)) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = r_rx_s;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_W'(CPB - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rx_s ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                // Hold off during a break until the line returns to idle.
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: stop-bit verdict and busy level for the next cycle.
    always_comb begin
        w_frame_good = 1'b0;
        w_frame_bad  = 1'b0;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        if (r_state == S_STOP && r_cnt == CNT_W'(CPB - 1)) begin
            w_frame_good = r_rx_s;
            w_frame_bad  = ~r_rx_s;
        end
    end

    // Holding register: a completing frame takes precedence over a simultaneous acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_rdy   <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_frame_good;
            if (w_frame_good) begin
                r_data_out <= r_shift;
                r_data_rdy <= 1'b1;
                if (w_ack_rise) begin
                    r_overrun   <= 1'b0;
                    r_frame_err <= 1'b0;
                end else begin
                    r_overrun <= r_overrun | r_data_rdy;
                end
            end else if (w_frame_bad) begin
                r_frame_err <= 1'b1;
                if (w_ack_rise) begin
                    r_data_rdy <= 1'b0;
                    r_overrun  <= 1'b0;
                end
            end else if (w_ack_rise) begin
                r_data_rdy  <= 1'b0;
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_rdy   = r_data_rdy;
    assign bus.overrun    = r_overrun;
    assign bus.frame_err  = r_frame_err;
    assign bus.data_valid = r_data_valid;
    assign bus.rx_busy    = r_busy;

endmodule
